alu_operand_stage: RTL and testbench

- Pipeline register directly upstream of the 32-bit ALU, whose operands are a, b and 3-bit function f and whose outputs are y and zero.
- Captures decoded operands, immediate and ALU function from decode through a valid/ready handshake.
- Resolves read-after-write hazards by forwarding from the two later stages.
- Presents a, b, f plus a valid flag to the ALU, and keeps a saturating stall counter for performance checks.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/fwd_mux.sv | 43 ++++
 rtl/alu_operand_stage.sv | 139 +++++++++++++
 tb/tb_alu_operand_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage.
// Holds the ALU function encodings, the hard-wired zero register address
// and the two-state occupancy enum of the operand pipeline register.
package alu_pkg;

  localparam int unsigned F_W        = 3;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [F_W-1:0] F_AND = 3'b000;
  localparam logic [F_W-1:0] F_OR  = 3'b001;
  localparam logic [F_W-1:0] F_ADD = 3'b010;
  localparam logic [F_W-1:0] F_SUB = 3'b110;
  localparam logic [F_W-1:0] F_SLT = 3'b111;

  // Register 0 reads as zero and must never pick up a forwarded value.
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } stage_e;

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one ALU operand.
// Ports:
//   src         - source register address held by the stage
//   reg_val     - register-file value captured with the operation
//   ex_*/wb_*   - write-back intent, destination and result of the two later stages
//   val         - resolved operand (combinational)
// EX is newer than WB, so it wins when both target the same register.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic [RADDR-1:0] src,
  input  logic [WIDTH-1:0] reg_val,
  input  logic             ex_regwrite,
  input  logic [RADDR-1:0] ex_dst,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             wb_regwrite,
  input  logic [RADDR-1:0] wb_dst,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] val
);

  localparam logic [RADDR-1:0] ZERO = RADDR'(REG_ZERO);

  logic ex_hit;
  logic wb_hit;

  assign ex_hit = ex_regwrite && (ex_dst != ZERO) && (ex_dst == src);
  assign wb_hit = wb_regwrite && (wb_dst != ZERO) && (wb_dst == src);

  // Two-level priority select.
  always_comb begin
    val = reg_val;
    if (ex_hit) begin
      val = ex_result;
    end else if (wb_hit) begin
      val = wb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand pipeline register in front of the 32-bit ALU.
// Accepts decoded operands through a valid/ready handshake, forwards results
// from the EX/MEM and MEM/WB stages onto the held operands every cycle, and
// counts cycles in which a valid operand set is stalled by the ALU side.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   in_valid/in_ready    - decode handshake (in_ready is combinational)
//   in_rd1, in_rd2       - register-file values for rs / rt
//   in_imm, in_alusrc    - immediate and B-operand select
//   in_f                 - ALU function code
//   in_rs, in_rt         - source register addresses
//   flush                - drop held and incoming operation
//   ex_*, wb_*           - forwarding sources from later stages
//   out_ready/out_valid  - ALU-side handshake
//   alu_a, alu_b, alu_f  - operands and function presented to the ALU
//   stall_count          - saturating count of stalled valid cycles
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rd1,
  input  logic [WIDTH-1:0] in_rd2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_alusrc,
  input  logic [F_W-1:0]   in_f,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic             flush,
  input  logic             ex_regwrite,
  input  logic [RADDR-1:0] ex_dst,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             wb_regwrite,
  input  logic [RADDR-1:0] wb_dst,
  input  logic [WIDTH-1:0] wb_result,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [F_W-1:0]   alu_f,
  output logic [CNT_W-1:0] stall_count
);

  stage_e           state_q;
  logic [WIDTH-1:0] rd1_q;
  logic [WIDTH-1:0] rd2_q;
  logic [WIDTH-1:0] imm_q;
  logic             alusrc_q;
  logic [F_W-1:0]   f_q;
  logic [RADDR-1:0] rs_q;
  logic [RADDR-1:0] rt_q;
  logic [CNT_W-1:0] stall_q;

  logic             load;
  logic             stalled;
  logic [WIDTH-1:0] fwd_b;

  assign out_valid   = (state_q == S_FULL);
  assign in_ready    = !out_valid || out_ready;
  assign load        = in_valid && in_ready && !flush;
  assign stalled     = out_valid && !out_ready && !flush;
  assign stall_count = stall_q;
  assign alu_f       = f_q;

  // Occupancy FSM, operand capture and stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_EMPTY;
      rd1_q    <= '0;
      rd2_q    <= '0;
      imm_q    <= '0;
      alusrc_q <= 1'b0;
      f_q      <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      stall_q  <= '0;
    end else begin
      if (load) begin
        rd1_q    <= in_rd1;
        rd2_q    <= in_rd2;
        imm_q    <= in_imm;
        alusrc_q <= in_alusrc;
        f_q      <= in_f;
        rs_q     <= in_rs;
        rt_q     <= in_rt;
      end

      case (state_q)
        S_EMPTY: if (load) state_q <= S_FULL;
        S_FULL: begin
          if (flush) begin
            state_q <= S_EMPTY;
          end else if (!load && out_ready) begin
            state_q <= S_EMPTY;
          end
        end
        default: state_q <= S_EMPTY;
      endcase

      if (stalled && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_a (
    .src         (rs_q),
    .reg_val     (rd1_q),
    .ex_regwrite (ex_regwrite),
    .ex_dst      (ex_dst),
    .ex_result   (ex_result),
    .wb_regwrite (wb_regwrite),
    .wb_dst      (wb_dst),
    .wb_result   (wb_result),
    .val         (alu_a)
  );

  fwd_mux #(.WIDTH(WIDTH), .RADDR(RADDR)) u_fwd_b (
    .src         (rt_q),
    .reg_val     (rd2_q),
    .ex_regwrite (ex_regwrite),
    .ex_dst      (ex_dst),
    .ex_result   (ex_result),
    .wb_regwrite (wb_regwrite),
    .wb_dst      (wb_dst),
    .wb_result   (wb_result),
    .val         (fwd_b)
  );

  // Immediates bypass forwarding entirely.
  assign alu_b = alusrc_q ? imm_q : fwd_b;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with an expected-operand scoreboard.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_rd1, in_rd2, in_imm;
  logic        in_alusrc;
  logic [2:0]  in_f;
  logic [4:0]  in_rs, in_rt;
  logic        flush;
  logic        ex_regwrite, wb_regwrite;
  logic [4:0]  ex_dst, wb_dst;
  logic [31:0] ex_result, wb_result;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_f;
  logic [15:0] stall_count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm), .in_alusrc(in_alusrc),
    .in_f(in_f), .in_rs(in_rs), .in_rt(in_rt), .flush(flush),
    .ex_regwrite(ex_regwrite), .ex_dst(ex_dst), .ex_result(ex_result),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_result(wb_result),
    .out_ready(out_ready), .out_valid(out_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_f(alu_f), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference forwarding: EX over WB, register 0 never forwarded.
  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rv);
    if (ex_regwrite && ex_dst != 5'd0 && ex_dst == src) return ex_result;
    if (wb_regwrite && wb_dst != 5'd0 && wb_dst == src) return wb_result;
    return rv;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Pop the oldest expected operand set and compare against the ALU-side outputs.
  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed output with empty scoreboard expected none", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_a"}, alu_a, e.a);
    chk({tag, "_b"}, alu_b, e.b);
    chk({tag, "_f"}, 32'(alu_f), 32'(e.f));
  endtask

  // Present an operation; the expectation uses the forwarding sources as they stand.
  task automatic set_op(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                        input logic alusrc, input logic [2:0] f, input logic [4:0] rs,
                        input logic [4:0] rt, input logic push);
    exp_t e;
    in_rd1 = rd1; in_rd2 = rd2; in_imm = imm; in_alusrc = alusrc;
    in_f = f; in_rs = rs; in_rt = rt; in_valid = 1'b1;
    if (push) begin
      e.a = fwd(rs, rd1);
      e.b = alusrc ? imm : fwd(rt, rd2);
      e.f = f;
      sb.push_back(e);
    end
  endtask

  // Clock an accepted op in, then sample away from the edge.
  task automatic accept();
    @(posedge clk);
    #1 in_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd1 = '0; in_rd2 = '0; in_imm = '0;
    in_alusrc = 1'b0; in_f = '0; in_rs = '0; in_rt = '0; flush = 1'b0;
    ex_regwrite = 1'b0; ex_dst = '0; ex_result = '0;
    wb_regwrite = 1'b0; wb_dst = '0; wb_result = '0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_b", alu_b, 32'd0);
    chk("rst_f", 32'(alu_f), 32'(F_AND));
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Basic SUB operands, no forwarding.
    set_op(32'h0000000A, 32'h00000005, 32'h0, 1'b0, F_SUB, 5'd1, 5'd2, 1'b1);
    accept();
    pop_chk("sub");

    // Forwarding onto rs=rt=3 from both stages; EX wins.
    ex_regwrite = 1'b1; ex_dst = 5'd3; ex_result = 32'h11111111;
    wb_regwrite = 1'b1; wb_dst = 5'd3; wb_result = 32'h22222222;
    set_op(32'h0000AAAA, 32'h0000BBBB, 32'h0, 1'b0, F_ADD, 5'd3, 5'd3, 1'b1);
    accept();
    pop_chk("fwd_ex");
    #1 ex_regwrite = 1'b0;
    #1;
    chk("fwd_wb_a", alu_a, 32'h22222222);
    chk("fwd_wb_b", alu_b, 32'h22222222);
    #1 wb_regwrite = 1'b0;
    #1;
    chk("fwd_none_a", alu_a, 32'h0000AAAA);
    chk("fwd_none_b", alu_b, 32'h0000BBBB);

    // Register 0 is never forwarded.
    ex_regwrite = 1'b1; ex_dst = 5'd0; wb_regwrite = 1'b1; wb_dst = 5'd0;
    set_op(32'h00000123, 32'h00000456, 32'h0, 1'b0, F_OR, 5'd0, 5'd0, 1'b1);
    accept();
    pop_chk("reg0");
    chk("reg0_a_raw", alu_a, 32'h00000123);

    // Immediate on B is not forwarded even though rt matches EX; A still forwards.
    ex_dst = 5'd4; ex_result = 32'h12345678; wb_regwrite = 1'b0;
    set_op(32'h00000007, 32'h00000009, 32'hFFFFFFFC, 1'b1, F_SLT, 5'd4, 5'd4, 1'b1);
    accept();
    pop_chk("imm");
    chk("imm_b_raw", alu_b, 32'hFFFFFFFC);
    ex_regwrite = 1'b0;

    // Stall for 5 cycles with a competing op offered.
    set_op(32'h00000100, 32'h00000200, 32'h0, 1'b0, F_OR, 5'd6, 5'd7, 1'b1);
    accept();
    pop_chk("stall_entry");
    out_ready = 1'b0;
    set_op(32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b0, F_AND, 5'd8, 5'd9, 1'b0);
    #1;
    chk("stall_ready", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clk);
    #2;
    chk("stall_cnt5", 32'(stall_count), 32'd5);
    chk("stall_hold_a", alu_a, 32'h00000100);
    chk("stall_hold_b", alu_b, 32'h00000200);
    chk("stall_hold_f", 32'(alu_f), 32'(F_OR));

    // Drain and reload in the same cycle.
    out_ready = 1'b1;
    set_op(32'h0000CAFE, 32'h0000BEEF, 32'h0, 1'b0, F_ADD, 5'd10, 5'd11, 1'b1);
    #1;
    chk("drain_ready", 32'(in_ready), 32'd1);
    accept();
    pop_chk("reload");
    chk("reload_cnt", 32'(stall_count), 32'd5);

    // Flush while full drops both entries and does not count as a stall.
    out_ready = 1'b0; flush = 1'b1;
    set_op(32'h0BADF00D, 32'h0BADF00D, 32'h0, 1'b0, F_SUB, 5'd12, 5'd13, 1'b0);
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_cnt", 32'(stall_count), 32'd5);
    @(posedge clk);
    #2;
    chk("flush_lost", 32'(out_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // Reset in the middle of a stall.
    out_ready = 1'b1;
    set_op(32'h00000055, 32'h00000066, 32'h0, 1'b0, F_AND, 5'd14, 5'd15, 1'b1);
    accept();
    pop_chk("pre_rst");
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_cnt", 32'(stall_count), 32'd8);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(stall_count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_a", alu_a, 32'd0);
    chk("mid_rst_f", 32'(alu_f), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
